fetch_unit_mq: RTL and testbench

//  Decoupled, parametrised instruction fetch front end: PC generation, predictor lookup, pipelined in-order

---
 rtl/fetch_unit_mq_pkg.sv | 27 ++
 rtl/fetch_unit_mq_if.sv | 26 ++
 rtl/fetch_unit_mq_fifo.sv | 56 +++++
 rtl/fetch_unit_mq.sv | 135 +++++++++++++
 tb/tb_fetch_unit_mq.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_mq_pkg.sv
// Shared types and helpers for the fetch front end.
//   fetch_entry_t   : one decoded-ready instruction queue entry
//   fetch_pending_t : bookkeeping for an imem request still awaiting its response
//   word_align()    : clears the byte-offset bits of a fetch address
package fetch_unit_mq_pkg;

    localparam logic [3:0] RMASK_WORD = 4'hF;
    localparam logic [3:0] RMASK_IDLE = 4'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_pending_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_mq_if.sv
// Bus bundle between the fetch unit and its neighbours.
//   imem side : imem_addr, imem_rmask (requests out), imem_resp, imem_rdata (responses in)
//   deq side  : deq_valid, deq_entry (head of instruction queue), deq_ready (consumer accept)
// master = fetch unit, slave = imem / decode environment.
interface fetch_unit_mq_if;
    import fetch_unit_mq_pkg::*;

    logic [31:0]  imem_addr;
    logic [3:0]   imem_rmask;
    logic         imem_resp;
    logic [31:0]  imem_rdata;
    logic         deq_valid;
    logic         deq_ready;
    fetch_entry_t deq_entry;

    modport master (
        output imem_addr, imem_rmask, deq_valid, deq_entry,
        input  imem_resp, imem_rdata, deq_ready
    );

    modport slave (
        input  imem_addr, imem_rmask, deq_valid, deq_entry,
        output imem_resp, imem_rdata, deq_ready
    );

endinterface

// File: rtl/fetch_unit_mq_fifo.sv
// fetch_fifo: synchronous circular FIFO with show-ahead read and flush.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   flush     : empties the FIFO at the next edge; overrides push/pop
//   push/wdata: write when not full
//   pop       : advance head when not empty
//   rdata     : current head (valid when !empty)
//   empty/full/count : occupancy; full/empty use one extra pointer bit
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH in their low bits; the top bit tells full from empty.
    assign wr_idx  = IW'(wr_ptr % PW'(DEPTH));
    assign rd_idx  = IW'(rd_ptr % PW'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_idx];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= wdata;
    end

endmodule

// File: rtl/fetch_unit_mq.sv
// fetch_unit_mq: decoupled instruction fetch front end.
//   clk, rst            : clock, synchronous active-high reset
//   branch_mispredict   : redirect; flushes the queue and refetches from branch_target
//   branch_target       : redirect PC (low 2 bits ignored)
//   pc_at_fetch         : PC presented to the predictor (same as imem_addr)
//   pred_taken/target   : combinational predictor result for pc_at_fetch
//   bus (master)        : imem request/response and instruction-queue dequeue port
// Up to MAX_OUTSTANDING in-order imem requests may be in flight. A request is only
// issued when the queue is guaranteed room for its response, so the queue cannot
// overflow. After a redirect, responses still in flight are counted as stale and
// dropped on arrival instead of tagging requests with an epoch.
module fetch_unit_mq
    import fetch_unit_mq_pkg::*;
#(
    parameter int          QUEUE_DEPTH     = 8,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h1eceb000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_mispredict,
    input  logic [31:0]     branch_target,
    output logic [31:0]     pc_at_fetch,
    input  logic            pred_taken,
    input  logic [31:0]     pred_target,
    fetch_unit_mq_if.master bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int QW = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]    pc;
    logic [OW-1:0]  inflight;
    logic [OW-1:0]  stale;

    logic           issue;
    logic           resp;
    logic           resp_keep;
    logic           deq_valid;
    logic           deq_fire;
    logic [31:0]    credit_used;

    fetch_pending_t pend_in, pend_head;
    fetch_entry_t   q_in, q_head;
    logic           pend_empty, pend_full;
    logic [OW-1:0]  pend_count;
    logic           q_empty, q_full;
    logic [QW-1:0]  q_count;
    logic           unused_status;

    // Entries already queued plus responses still to be kept must fit the queue.
    // stale never exceeds inflight, so the subtraction cannot wrap.
    assign credit_used = 32'(q_count) + 32'(inflight) - 32'(stale);

    assign issue = !rst && !branch_mispredict
                && (32'(inflight) < 32'(MAX_OUTSTANDING))
                && (credit_used < 32'(QUEUE_DEPTH));

    assign resp      = bus.imem_resp && !rst;
    assign resp_keep = resp && !branch_mispredict && (stale == '0);

    // The head is hidden during a redirect so nothing is consumed from a flushed queue.
    assign deq_valid = !q_empty && !rst && !branch_mispredict;
    assign deq_fire  = deq_valid && bus.deq_ready;

    assign pc_at_fetch    = pc;
    assign bus.imem_addr  = pc;
    assign bus.imem_rmask = issue ? RMASK_WORD : RMASK_IDLE;
    assign bus.deq_valid  = deq_valid;
    assign bus.deq_entry  = q_head;

    assign pend_in = '{pc: pc, pred_taken: pred_taken, pred_target: word_align(pred_target)};

    assign q_in = '{pc:          pend_head.pc,
                    inst:        bus.imem_rdata,
                    pred_taken:  pend_head.pred_taken,
                    pred_target: pend_head.pred_target};

    // Pending tracker: popped on every response, stale or not, so it stays aligned
    // with the imem's in-order responses across redirects.
    fetch_fifo #(
        .WIDTH ($bits(fetch_pending_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pending (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (issue),
        .wdata (pend_in),
        .pop   (resp),
        .rdata (pend_head),
        .empty (pend_empty),
        .full  (pend_full),
        .count (pend_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_mispredict),
        .push  (resp_keep),
        .wdata (q_in),
        .pop   (deq_fire),
        .rdata (q_head),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    // Status outputs the issue logic does not need (it tracks inflight itself).
    assign unused_status = &{1'b0, pend_empty, pend_full, pend_count, q_full};

    // NOTE: state registers use non-blocking assignment so every update below sees
    // the pre-edge values of pc, inflight and stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= '0;
            stale    <= '0;
        end else begin
            inflight <= inflight + OW'(issue) - OW'(resp);
            if (branch_mispredict) begin
                // Everything still outstanding after this cycle belongs to the old path.
                pc    <= word_align(branch_target);
                stale <= inflight - OW'(resp);
            end else begin
                if (issue) pc <= pred_taken ? word_align(pred_target) : pc + 32'd4;
                if (resp && (stale != '0)) stale <= stale - OW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit_mq.sv
// Directed self-checking bench for fetch_unit_mq with a small in-order imem model
// of configurable latency and a single-PC predictor model.
module tb_fetch_unit_mq;
    import fetch_unit_mq_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_mispredict;
    logic [31:0] branch_target;
    logic [31:0] pc_at_fetch;
    logic        pred_taken;
    logic [31:0] pred_target;

    fetch_unit_mq_if bus ();

    fetch_unit_mq dut (
        .clk               (clk),
        .rst               (rst),
        .branch_mispredict (branch_mispredict),
        .branch_target     (branch_target),
        .pc_at_fetch       (pc_at_fetch),
        .pred_taken        (pred_taken),
        .pred_target       (pred_target),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    int           lat   = 1;
    logic         pred_en  = 1'b0;
    logic [31:0]  pred_pc  = '0;
    logic [31:0]  pred_tgt = '0;
    req_t         mq[$];
    logic [31:0]  issued[$];
    fetch_entry_t deqd[$];
    logic [3:0]   last_rmask;
    logic [31:0]  last_addr;
    logic         last_deq_valid;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] iss(input int i);
        return (i < issued.size()) ? issued[i] : 32'hdead_dead;
    endfunction

    function automatic fetch_entry_t deq(input int i);
        fetch_entry_t e;
        e = '{pc: 32'hdead_dead, inst: 32'hdead_dead, pred_taken: 1'b0, pred_target: 32'hdead_dead};
        if (i < deqd.size()) e = deqd[i];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: present imem response and predictor result, sample outputs
    // 1ns later (well before the rising edge), log issues and dequeues.
    task automatic cycle();
        req_t r;
        pred_taken  = pred_en && (pc_at_fetch == pred_pc);
        pred_target = pred_tgt;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = inst_of(r.addr);
        end else begin
            bus.imem_resp  = 1'b0;
            bus.imem_rdata = '0;
        end
        #1;
        last_rmask     = bus.imem_rmask;
        last_addr      = bus.imem_addr;
        last_deq_valid = bus.deq_valid;
        if (!rst && bus.imem_rmask == 4'hF) begin
            mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
            issued.push_back(bus.imem_addr);
        end
        if (bus.deq_valid && bus.deq_ready) deqd.push_back(bus.deq_entry);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input string tag);
        rst               = 1'b1;
        branch_mispredict = 1'b0;
        bus.deq_ready     = 1'b1;
        pred_en           = 1'b0;
        mq.delete();
        repeat (2) begin
            cycle();
            check({tag, "_rst_rmask"}, 32'(last_rmask), 32'h0);
            check({tag, "_rst_deq_valid"}, 32'(last_deq_valid), 32'h0);
        end
        rst = 1'b0;
        issued.delete();
        deqd.delete();
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        branch_mispredict = 1'b0;
        branch_target     = '0;
        pred_taken        = 1'b0;
        pred_target       = '0;
        bus.imem_resp     = 1'b0;
        bus.imem_rdata    = '0;
        bus.deq_ready     = 1'b1;

        // 1: sequential fetch, 1-cycle imem, always ready
        lat = 1;
        do_reset("t1");
        cycle();
        check("t1_c0_addr", last_addr, 32'h1eceb000);
        check("t1_c0_deq_valid", 32'(last_deq_valid), 32'h0);
        cycle();
        check("t1_c1_no_bypass", 32'(last_deq_valid), 32'h0);
        repeat (6) cycle();
        check("t1_issue_count", 32'(issued.size()), 32'd8);
        check("t1_addr1", iss(1), 32'h1eceb004);
        check("t1_addr2", iss(2), 32'h1eceb008);
        check("t1_deq_count", 32'(deqd.size()), 32'd6);
        check("t1_deq0_pc", deq(0).pc, 32'h1eceb000);
        check("t1_deq0_inst", deq(0).inst, inst_of(32'h1eceb000));
        check("t1_deq1_pc", deq(1).pc, 32'h1eceb004);
        check("t1_deq5_pc", deq(5).pc, 32'h1eceb014);

        // 2: consumer stalled -> exactly QUEUE_DEPTH issued, then resume
        do_reset("t2");
        bus.deq_ready = 1'b0;
        repeat (20) cycle();
        check("t2_issue_count", 32'(issued.size()), 32'd8);
        check("t2_rmask_idle", 32'(last_rmask), 32'h0);
        check("t2_deq_valid", 32'(last_deq_valid), 32'h1);
        check("t2_no_deq", 32'(deqd.size()), 32'd0);
        bus.deq_ready = 1'b1;
        cycle();
        check("t2_resume_rmask_c0", 32'(last_rmask), 32'h0);
        check("t2_resume_deq", 32'(deqd.size()), 32'd1);
        cycle();
        check("t2_resume_rmask_c1", 32'(last_rmask), 32'hF);
        check("t2_resume_addr", last_addr, 32'h1eceb020);
        repeat (10) cycle();
        check("t2_deq0_pc", deq(0).pc, 32'h1eceb000);
        check("t2_deq7_pc", deq(7).pc, 32'h1eceb01c);
        check("t2_deq8_pc", deq(8).pc, 32'h1eceb020);

        // 3: predicted-taken at 1eceb004, target with stray low bits
        do_reset("t3");
        pred_en  = 1'b1;
        pred_pc  = 32'h1eceb004;
        pred_tgt = 32'h1eceb102;
        repeat (6) cycle();
        pred_en = 1'b0;
        check("t3_addr2", iss(2), 32'h1eceb100);
        check("t3_addr3", iss(3), 32'h1eceb104);
        check("t3_deq0_pred", 32'(deq(0).pred_taken), 32'h0);
        check("t3_deq1_pc", deq(1).pc, 32'h1eceb004);
        check("t3_deq1_pred", 32'(deq(1).pred_taken), 32'h1);
        check("t3_deq1_tgt", deq(1).pred_target, 32'h1eceb100);
        check("t3_deq2_pc", deq(2).pc, 32'h1eceb100);
        check("t3_deq2_inst", deq(2).inst, inst_of(32'h1eceb100));

        // 4: two in flight at latency 3, redirect drops both
        do_reset("t4");
        lat = 3;
        cycle();
        cycle();
        branch_mispredict = 1'b1;
        branch_target     = 32'h1eceb201;
        cycle();
        check("t4_mp_rmask", 32'(last_rmask), 32'h0);
        branch_mispredict = 1'b0;
        repeat (10) cycle();
        check("t4_addr2", iss(2), 32'h1eceb200);
        check("t4_deq0_pc", deq(0).pc, 32'h1eceb200);
        check("t4_deq0_inst", deq(0).inst, inst_of(32'h1eceb200));

        // 5: redirect coinciding with a response and a ready consumer
        do_reset("t5");
        lat = 1;
        repeat (3) cycle();
        branch_mispredict = 1'b1;
        branch_target     = 32'h1eceb300;
        cycle();
        check("t5_mp_deq_valid", 32'(last_deq_valid), 32'h0);
        check("t5_mp_rmask", 32'(last_rmask), 32'h0);
        branch_mispredict = 1'b0;
        cycle();
        check("t5_after_deq_valid", 32'(last_deq_valid), 32'h0);
        check("t5_after_rmask", 32'(last_rmask), 32'hF);
        check("t5_after_addr", last_addr, 32'h1eceb300);
        repeat (5) cycle();
        check("t5_deq0_pc", deq(0).pc, 32'h1eceb000);
        check("t5_deq1_pc", deq(1).pc, 32'h1eceb300);

        // 6: reset mid-stream with a request in flight
        do_reset("t6a");
        lat = 3;
        repeat (5) cycle();
        check("t6_inflight_before", 32'(mq.size()), 32'd1);
        do_reset("t6b");
        cycle();
        check("t6_first_rmask", 32'(last_rmask), 32'hF);
        check("t6_first_addr", last_addr, 32'h1eceb000);
        repeat (6) cycle();
        check("t6_deq0_pc", deq(0).pc, 32'h1eceb000);
        check("t6_deq0_inst", deq(0).inst, inst_of(32'h1eceb000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
